// File: rtl/vga_pkg.sv
// Timing constants per video mode and helpers deriving total line/frame lengths.
// Add further resolutions as additional constant groups alongside the 640x480@60 set.
package vga_pkg;

  localparam int H_PW_640  = 96;
  localparam int H_BP_640  = 48;
  localparam int H_ACT_640 = 640;
  localparam int H_FP_640  = 16;
  localparam int V_PW_640  = 2;
  localparam int V_BP_640  = 33;
  localparam int V_ACT_640 = 480;
  localparam int V_FP_640  = 10;

  function automatic int h_tot(input int pw, input int bp, input int act, input int fp);
    return pw + bp + act + fp;
  endfunction

  function automatic int v_tot(input int pw, input int bp, input int act, input int fp);
    return pw + bp + act + fp;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter with combinational sync/active decode and active offset.
// Counter advances on inc only; wrap is a same-cycle pulse on the inc that leaves TOT-1.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int W   = 11,
  parameter int TOT = 800,
  parameter int PW  = 96,
  parameter int BP  = 48,
  parameter int ACT = 640
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         sync_act,
  output logic         act,
  output logic [W-1:0] pos
);

  localparam logic [W-1:0] LAST     = W'(TOT - 1);
  localparam logic [W-1:0] SYNC_END = W'(PW);
  localparam logic [W-1:0] ACT_BEG  = W'(PW + BP);
  localparam logic [W-1:0] ACT_END  = W'(PW + BP + ACT);

  assign wrap     = inc && (cnt == LAST);
  assign sync_act = (cnt < SYNC_END);
  assign act      = (cnt >= ACT_BEG) && (cnt < ACT_END);
  assign pos      = act ? (cnt - ACT_BEG) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : (cnt + W'(1));
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: registered hs/vs/de/x/y and line/frame strobes, 1 clk after the counters, paced by pix_ce.
// No backpressure; pix_ce=0 freezes state and drops strobes. Define VGA_FRAME_CNT_EN to add frame_cnt.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_PW       = H_PW_640,
  parameter int H_BP       = H_BP_640,
  parameter int H_ACT      = H_ACT_640,
  parameter int H_FP       = H_FP_640,
  parameter int V_PW       = V_PW_640,
  parameter int V_BP       = V_BP_640,
  parameter int V_ACT      = V_ACT_640,
  parameter int V_FP       = V_FP_640,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int XW         = 11,
  parameter int YW         = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_ce,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]    frame_cnt
`endif
);

  localparam int   H_TOT = h_tot(H_PW, H_BP, H_ACT, H_FP);
  localparam int   V_TOT = v_tot(V_PW, V_BP, V_ACT, V_FP);
  localparam logic HS_ON = (H_SYNC_POL != 0);
  localparam logic VS_ON = (V_SYNC_POL != 0);

  if (H_TOT >= (1 << XW)) begin : g_h_too_wide
    $error("vga_timing_gen: H_TOT=%0d does not fit in XW=%0d bits", H_TOT, XW);
  end
  if (V_TOT >= (1 << YW)) begin : g_v_too_wide
    $error("vga_timing_gen: V_TOT=%0d does not fit in YW=%0d bits", V_TOT, YW);
  end

  logic [XW-1:0] h_cnt, h_pos;
  logic [YW-1:0] v_cnt, v_pos;
  logic          h_wrap, h_sync, h_act;
  logic          v_wrap_unused, v_sync, v_act;
  logic          first_px, frame_first;

  vga_axis_cnt #(.W(XW), .TOT(H_TOT), .PW(H_PW), .BP(H_BP), .ACT(H_ACT)) u_h (
    .clk(clk), .rst_n(rst_n), .inc(pix_ce),
    .cnt(h_cnt), .wrap(h_wrap), .sync_act(h_sync), .act(h_act), .pos(h_pos)
  );

  vga_axis_cnt #(.W(YW), .TOT(V_TOT), .PW(V_PW), .BP(V_BP), .ACT(V_ACT)) u_v (
    .clk(clk), .rst_n(rst_n), .inc(pix_ce & h_wrap),
    .cnt(v_cnt), .wrap(v_wrap_unused), .sync_act(v_sync), .act(v_act), .pos(v_pos)
  );

  assign first_px    = (h_cnt == '0);
  assign frame_first = first_px && (v_cnt == '0);

  // Outputs reflect the pre-increment counters; strobes only live for the clk of their pix_ce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs          <= ~HS_ON;
      vs          <= ~VS_ON;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      hs          <= h_sync ? HS_ON : ~HS_ON;
      vs          <= v_sync ? VS_ON : ~VS_ON;
      de          <= h_act && v_act;
      x           <= (h_act && v_act) ? h_pos : '0;
      y           <= (h_act && v_act) ? v_pos : '0;
      line_start  <= first_px;
      frame_start <= frame_first;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (pix_ce && frame_first) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance for long periods, tiny instance for tables and model runs.
module tb_vga_timing_gen;

  localparam int SH_PW = 2, SH_BP = 1, SH_ACT = 8, SH_FP = 1;
  localparam int SV_PW = 1, SV_BP = 1, SV_ACT = 4, SV_FP = 1;
  localparam int SH_TOT  = SH_PW + SH_BP + SH_ACT + SH_FP;
  localparam int SV_TOT  = SV_PW + SV_BP + SV_ACT + SV_FP;
  localparam int S_FRAME = SH_TOT * SV_TOT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] x;
    logic [9:0]  y;
    logic        ls;
    logic        fs;
  } out_t;

  typedef struct {
    int   k;
    out_t e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, ce_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [10:0] x_a;
  logic [9:0]  y_a;
  logic        rst_b, ce_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [10:0] x_b;
  logic [9:0]  y_b;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]  fc_a, fc_b;
`endif

  out_t sm_o;
  assign sm_o = {hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b};

  vga_timing_gen dut_def (
    .clk(clk), .rst_n(rst_a), .pix_ce(ce_a), .hs(hs_a), .vs(vs_a), .de(de_a),
    .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  vga_timing_gen #(
    .H_PW(SH_PW), .H_BP(SH_BP), .H_ACT(SH_ACT), .H_FP(SH_FP),
    .V_PW(SV_PW), .V_BP(SV_BP), .V_ACT(SV_ACT), .V_FP(SV_FP),
    .H_SYNC_POL(1), .V_SYNC_POL(1), .XW(11), .YW(10)
  ) dut_sm (
    .clk(clk), .rst_n(rst_b), .pix_ce(ce_b), .hs(hs_b), .vs(vs_b), .de(de_b),
    .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  int   p = 0;
  bit   last_ce = 1'b0;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_out(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (p=%0d): got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b expected hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
               name, p, act.hs, act.vs, act.de, act.x, act.y, act.ls, act.fs,
               exp.hs, exp.vs, exp.de, exp.x, exp.y, exp.ls, exp.fs);
    end
  endtask

  function automatic out_t mk(input bit hs, input bit vs, input bit de, input int x, input int y,
                              input bit ls, input bit fs);
    out_t o;
    o.hs = hs; o.vs = vs; o.de = de; o.x = 11'(x); o.y = 10'(y); o.ls = ls; o.fs = fs;
    return o;
  endfunction

  // Reference for the small instance: n pix_ce edges since reset place the raster at pixel n-1.
  function automatic out_t model_sm(input int n, input bit ce_prev);
    int q, h, v;
    bit de;
    if (n == 0) return mk(0, 0, 0, 0, 0, 0, 0);
    q  = n - 1;
    h  = q % SH_TOT;
    v  = (q / SH_TOT) % SV_TOT;
    de = (h >= SH_PW + SH_BP) && (h < SH_PW + SH_BP + SH_ACT) &&
         (v >= SV_PW + SV_BP) && (v < SV_PW + SV_BP + SV_ACT);
    return mk(h < SH_PW, v < SV_PW, de,
              de ? h - (SH_PW + SH_BP) : 0, de ? v - (SV_PW + SV_BP) : 0,
              ce_prev && h == 0, ce_prev && h == 0 && v == 0);
  endfunction

  function automatic int model_fc(input int n);
    return (n == 0) ? 0 : (((n - 1) / S_FRAME) + 1) % 256;
  endfunction

  // Asserts reset between edges, checks the immediate effect, releases with pix_ce low.
  task automatic sm_async_reset();
    #2;
    rst_b   = 1'b0;
    p       = 0;
    last_ce = 1'b0;
    #1;
    cmp_out("sm_async_rst", sm_o, model_sm(0, 1'b0));
`ifdef VGA_FRAME_CNT_EN
    chk("fc_async_rst", fc_b, 0);
`endif
    @(negedge clk);
    ce_b  = 1'b0;
    rst_b = 1'b1;
  endtask

  // mode 0: pix_ce every 4th clk, 1: random pix_ce with random resets, 2: pix_ce always high
  task automatic run_sm(input int ncyc, input int mode);
    int last_ls = -1;
    int last_fs = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      case (mode)
        0:       ce_b = (c % 4 == 0);
        1:       ce_b = ($urandom_range(0, 1) == 1);
        default: ce_b = 1'b1;
      endcase
      @(posedge clk);
      #1;
      if (ce_b) p++;
      last_ce = ce_b;
      cmp_out("sm_model", sm_o, model_sm(p, last_ce));
`ifdef VGA_FRAME_CNT_EN
      chk("fc_model", fc_b, model_fc(p));
`endif
      if (mode == 0 && ls_b) begin
        if (last_ls >= 0) chk("ls_period_x4", c - last_ls, 4 * SH_TOT);
        last_ls = c;
      end
      if (mode == 0 && fs_b) begin
        if (last_fs >= 0) chk("fs_period_x4", c - last_fs, 4 * S_FRAME);
        last_fs = c;
      end
      if (mode == 1 && $urandom_range(0, 299) == 0) sm_async_reset();
    end
  endtask

  initial begin
    int k, n, hs_rise, hs_fall, vs_rise, de_first, de_cnt, fx, fy, lx, ly, gap;
    rst_a = 1'b0; rst_b = 1'b0; ce_a = 1'b0; ce_b = 1'b0;

    // after k pix_ce edges from reset (hs/vs active high on the small instance)
    tbl[0]  = '{1,  mk(1, 1, 0, 0, 0, 1, 1)};
    tbl[1]  = '{2,  mk(1, 1, 0, 0, 0, 0, 0)};
    tbl[2]  = '{3,  mk(0, 1, 0, 0, 0, 0, 0)};
    tbl[3]  = '{12, mk(0, 1, 0, 0, 0, 0, 0)};
    tbl[4]  = '{13, mk(1, 0, 0, 0, 0, 1, 0)};
    tbl[5]  = '{28, mk(0, 0, 1, 0, 0, 0, 0)};
    tbl[6]  = '{35, mk(0, 0, 1, 7, 0, 0, 0)};
    tbl[7]  = '{36, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{71, mk(0, 0, 1, 7, 3, 0, 0)};
    tbl[9]  = '{84, mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{85, mk(1, 1, 0, 0, 0, 1, 1)};

    repeat (2) @(negedge clk);
    chk("def_rst_hs", hs_a, 1);
    chk("def_rst_vs", vs_a, 1);
    chk("def_rst_de", de_a, 0);
    chk("def_rst_ls", ls_a, 0);
    chk("def_rst_fs", fs_a, 0);
    cmp_out("sm_rst", sm_o, mk(0, 0, 0, 0, 0, 0, 0));

    // Default 640x480 timing at full rate
    @(negedge clk);
    rst_a = 1'b1; ce_a = 1'b1;
    hs_rise = -1; hs_fall = -1; vs_rise = -1; de_first = -1; de_cnt = 0;
    fx = -1; fy = -1; lx = -1; ly = -1;
    for (n = 1; n <= 29000; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        chk("def_first_fs", fs_a, 1);
        chk("def_first_ls", ls_a, 1);
        chk("def_first_hs", hs_a, 0);
        chk("def_first_vs", vs_a, 0);
      end
      if (hs_rise < 0 && hs_a) hs_rise = n;
      else if (hs_rise > 0 && hs_fall < 0 && !hs_a) hs_fall = n;
      if (vs_rise < 0 && vs_a) vs_rise = n;
      if (de_a) begin
        if (de_first < 0) begin
          de_first = n; fx = int'(x_a); fy = int'(y_a);
        end
        if (n < de_first + 800) begin
          de_cnt++; lx = int'(x_a); ly = int'(y_a);
        end
      end
    end
    chk("def_hs_low_width", hs_rise - 1, 96);
    chk("def_hs_period", hs_fall - 1, 800);
    chk("def_vs_low_width", vs_rise - 1, 1600);
    chk("def_de_first_line", (de_first - 1) / 800, 35);
    chk("def_de_first_offset", (de_first - 1) % 800, 144);
    chk("def_de_first_x", fx, 0);
    chk("def_de_first_y", fy, 0);
    chk("def_de_per_line", de_cnt, 640);
    chk("def_de_last_x", lx, 639);
    chk("def_de_last_y", ly, 0);

    // Async reset mid-frame on the default instance
    @(posedge clk);
    #3;
    rst_a = 1'b0;
    #1;
    chk("def_mid_rst_hs", hs_a, 1);
    chk("def_mid_rst_vs", vs_a, 1);
    chk("def_mid_rst_de", de_a, 0);
    chk("def_mid_rst_x", x_a, 0);
    chk("def_mid_rst_y", y_a, 0);
    @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    chk("def_post_rst_fs", fs_a, 1);
    chk("def_post_rst_hs", hs_a, 0);
    chk("def_post_rst_vs", vs_a, 0);
    ce_a = 1'b0;

    // Small instance: table of positions at full rate
    @(negedge clk);
    rst_b = 1'b1; ce_b = 1'b1; k = 0;
    foreach (tbl[i]) begin
      while (k < tbl[i].k) begin
        @(posedge clk);
        #1;
        k++;
      end
      cmp_out($sformatf("vec%0d_k%0d", i, tbl[i].k), sm_o, tbl[i].e);
    end
    p = k; last_ce = 1'b1;

    // pix_ce every 4th clk for three frames
    run_sm(3 * 4 * S_FRAME, 0);

    // Reset mid-frame at v_cnt=3, then first pix_ce must start a frame
    gap = ((3 * SH_TOT + 5) - (p % S_FRAME) + S_FRAME) % S_FRAME;
    run_sm(gap, 2);
    sm_async_reset();
    run_sm(1, 2);
    chk("sm_post_rst_fs", fs_b, 1);
    chk("sm_post_rst_hs", hs_b, 1);
    chk("sm_post_rst_vs", vs_b, 1);

    run_sm(4000, 1);

`ifdef VGA_FRAME_CNT_EN
    sm_async_reset();
    run_sm(255 * S_FRAME, 2);
    chk("fc_at_255", fc_b, 255);
    run_sm(1, 2);
    chk("fc_wrap", fc_b, 0);
    sm_async_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
